piezo_chime_seq: RTL and testbench

- Parametrised successor of the single-cuckoo piezo driver. Drives a piezo square wave from an N-key piano input or from an hour-chime sequencer.
- The sequencer plays a two-tone "cuckoo" (high note, then low note) once per strike, with a programmable strike count (e.g. hour of day).
- Sits between the clock/time core (trigger and hour value) and the board piezo pin.
- Timing is in clk cycles (1 MHz clk gives 1 cycle = 1 us).

---
 rtl/piezo_chime_seq.sv | 164 ++++++++++++++++
 tb/tb_piezo_chime_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_chime_seq.sv
// Piezo square-wave driver: N-key piano input plus an hour-chime "cuckoo" sequencer.
// Each strike plays a high note, a gap, a low note and a strike gap. Keys are blocked while the chime runs.
module piezo_chime_seq #(
  parameter int NUM_KEYS   = 8,
  parameter int PER_W      = 16,
  parameter int DUR_W      = 20,
  parameter int CHIME_HI   = 2550,
  parameter int CHIME_LO   = 3038,
  parameter int TONE_ON    = 100000,
  parameter int TONE_GAP   = 50000,
  parameter int STRIKE_GAP = 300000,
  parameter int CNT_W      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_KEYS-1:0]       i_btn,
  input  logic [NUM_KEYS*PER_W-1:0] i_key_period,
  input  logic                      i_hour_chime_trig,
  input  logic [CNT_W-1:0]          i_strike_count,
  input  logic                      i_chime_cancel,
  input  logic                      i_mute,
  output logic                      o_piezo,
  output logic                      o_chime_busy,
  output logic [CNT_W-1:0]          o_strikes_left
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NOTE_HI,
    S_GAP1,
    S_NOTE_LO,
    S_GAP2
  } state_t;

  localparam logic [DUR_W-1:0] L_ON_END    = DUR_W'(TONE_ON - 1);
  localparam logic [DUR_W-1:0] L_GAP_END   = DUR_W'(TONE_GAP - 1);
  localparam logic [DUR_W-1:0] L_STRK_END  = DUR_W'(STRIKE_GAP - 1);
  localparam logic [PER_W-1:0] L_PER_HI    = PER_W'(CHIME_HI);
  localparam logic [PER_W-1:0] L_PER_LO    = PER_W'(CHIME_LO);

  state_t             r_state;
  state_t             w_next_state;
  logic [DUR_W-1:0]   r_dur;
  logic [DUR_W-1:0]   w_next_dur;
  logic [CNT_W-1:0]   r_strikes;
  logic [CNT_W-1:0]   w_next_strikes;
  logic [CNT_W-1:0]   w_strikes_dec;

  logic [PER_W-1:0]   w_key_per;
  logic [PER_W-1:0]   w_period;
  logic [PER_W-1:0]   w_half;
  logic [PER_W-1:0]   r_prev_period;
  logic [PER_W-1:0]   r_cnt;
  logic               r_piezo;

  assign w_strikes_dec = r_strikes - CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_dur     <= '0;
      r_strikes <= '0;
    end else begin
      r_state   <= w_next_state;
      r_dur     <= w_next_dur;
      r_strikes <= w_next_strikes;
    end
  end

  // Cancel overrides every timed state; in IDLE it also vetoes a same-cycle trigger.
  always_comb begin
    w_next_state   = r_state;
    w_next_dur     = r_dur + DUR_W'(1);
    w_next_strikes = r_strikes;
    if (r_state == S_IDLE) begin
      w_next_dur = '0;
      if (i_hour_chime_trig && (i_strike_count != '0) && !i_chime_cancel) begin
        w_next_strikes = i_strike_count;
        w_next_state   = S_NOTE_HI;
      end
    end else if (i_chime_cancel) begin
      w_next_state   = S_IDLE;
      w_next_dur     = '0;
      w_next_strikes = '0;
    end else begin
      case (r_state)
        S_NOTE_HI: if (r_dur == L_ON_END) begin
          w_next_state = S_GAP1;
          w_next_dur   = '0;
        end
        S_GAP1: if (r_dur == L_GAP_END) begin
          w_next_state = S_NOTE_LO;
          w_next_dur   = '0;
        end
        S_NOTE_LO: if (r_dur == L_ON_END) begin
          w_next_state = S_GAP2;
          w_next_dur   = '0;
        end
        S_GAP2: if (r_dur == L_STRK_END) begin
          w_next_dur     = '0;
          w_next_strikes = w_strikes_dec;
          w_next_state   = (w_strikes_dec != '0) ? S_NOTE_HI : S_IDLE;
        end
        default: begin
          w_next_state   = S_IDLE;
          w_next_dur     = '0;
          w_next_strikes = '0;
        end
      endcase
    end
  end

  // Highest pressed key wins, so later loop iterations overwrite earlier ones.
  always_comb begin
    w_key_per = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (i_btn[i]) w_key_per = i_key_period[i*PER_W +: PER_W];
    end
  end

  always_comb begin
    w_period = '0;
    if (i_mute) begin
      w_period = '0;
    end else begin
      case (r_state)
        S_NOTE_HI: w_period = L_PER_HI;
        S_NOTE_LO: w_period = L_PER_LO;
        S_GAP1:    w_period = '0;
        S_GAP2:    w_period = '0;
        default:   w_period = w_key_per;
      endcase
    end
  end

  assign w_half = w_period >> 1;

  // A pitch change restarts the half-period count but keeps the pin level, avoiding a glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_piezo       <= 1'b0;
      r_cnt         <= '0;
      r_prev_period <= '0;
    end else begin
      r_prev_period <= w_period;
      if (w_period < PER_W'(2)) begin
        r_piezo <= 1'b0;
        r_cnt   <= '0;
      end else if (w_period != r_prev_period) begin
        r_cnt <= '0;
      end else if (r_cnt == (w_half - PER_W'(1))) begin
        r_cnt   <= '0;
        r_piezo <= ~r_piezo;
      end else begin
        r_cnt <= r_cnt + PER_W'(1);
      end
    end
  end

  assign o_piezo        = r_piezo;
  assign o_chime_busy   = (r_state != S_IDLE);
  assign o_strikes_left = r_strikes;

endmodule

// File: tb/tb_piezo_chime_seq.sv
// Self-checking bench for piezo_chime_seq: directed scenarios then randomized traffic,
// compared every cycle against a timeline-based reference model.
module tb_piezo_chime_seq;

  localparam int NK    = 8;
  localparam int PW    = 16;
  localparam int TON   = 20;
  localparam int TGAP  = 10;
  localparam int SGAP  = 30;
  localparam int PHI   = 8;
  localparam int PLO   = 12;
  localparam int SLEN  = 2*TON + TGAP + SGAP;

  logic          clk;
  logic          rst;
  logic [NK-1:0] btn;
  logic [NK*PW-1:0] keyPeriod;
  logic          trig;
  logic [3:0]    strikeCount;
  logic          cancel;
  logic          mute;
  logic          piezo;
  logic          busy;
  logic [3:0]    strikesLeft;

  int checks = 0;
  int errors = 0;

  // Reference model: the sequencer is a timeline (elapsed cycles since start), the tone is a run-length counter.
  bit mBusy;
  int mEl;
  int mCount;
  int mPrevP;
  int mSince;
  bit mPiezo;

  piezo_chime_seq #(
    .NUM_KEYS(NK), .PER_W(PW), .DUR_W(20),
    .CHIME_HI(PHI), .CHIME_LO(PLO),
    .TONE_ON(TON), .TONE_GAP(TGAP), .STRIKE_GAP(SGAP), .CNT_W(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn(btn),
    .i_key_period(keyPeriod),
    .i_hour_chime_trig(trig),
    .i_strike_count(strikeCount),
    .i_chime_cancel(cancel),
    .i_mute(mute),
    .o_piezo(piezo),
    .o_chime_busy(busy),
    .o_strikes_left(strikesLeft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelPeriod();
    int off;
    if (mute) return 0;
    if (mBusy) begin
      off = mEl % SLEN;
      if (off < TON) return PHI;
      if (off < TON + TGAP) return 0;
      if (off < 2*TON + TGAP) return PLO;
      return 0;
    end
    for (int i = NK-1; i >= 0; i--) begin
      if (btn[i]) return int'(keyPeriod[i*PW +: PW]);
    end
    return 0;
  endfunction

  function automatic void modelReset();
    mBusy  = 1'b0;
    mEl    = 0;
    mCount = 0;
    mPrevP = 0;
    mSince = 0;
    mPiezo = 1'b0;
  endfunction

  function automatic void modelEdge();
    int p;
    p = modelPeriod();
    if (p < 2) begin
      mPiezo = 1'b0;
      mSince = 0;
    end else if (p != mPrevP) begin
      mSince = 0;
    end else begin
      mSince++;
      if (mSince == p / 2) begin
        mPiezo = !mPiezo;
        mSince = 0;
      end
    end
    mPrevP = p;
    if (!mBusy) begin
      if (trig && strikeCount != 0 && !cancel) begin
        mBusy  = 1'b1;
        mEl    = 0;
        mCount = int'(strikeCount);
      end
    end else if (cancel) begin
      mBusy = 1'b0;
    end else begin
      mEl++;
      if (mEl == mCount * SLEN) mBusy = 1'b0;
    end
  endfunction

  task automatic compareAll();
    checkOutput("piezo", piezo, mPiezo);
    checkOutput("chimeBusy", busy, mBusy);
    checkOutput("strikesLeft", strikesLeft, mBusy ? (mCount - mEl / SLEN) : 0);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model and compare.
  task automatic applyStimulus(input logic [NK-1:0] b, input logic t, input logic [3:0] sc,
                               input logic c, input logic m);
    btn         = b;
    trig        = t;
    strikeCount = sc;
    cancel      = c;
    mute        = m;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear before any clock edge.
  task automatic doReset();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstPiezo", piezo, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstStrikes", strikesLeft, 4'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [NK-1:0] rb;
    logic rm;

    rst         = 1'b1;
    btn         = '0;
    trig        = 1'b0;
    strikeCount = '0;
    cancel      = 1'b0;
    mute        = 1'b0;
    keyPeriod   = '0;
    for (int i = 1; i < NK-1; i++) keyPeriod[i*PW +: PW] = PW'($urandom_range(0, 15));
    keyPeriod[0*PW +: PW] = 16'd6;
    keyPeriod[7*PW +: PW] = 16'd4;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("resetPiezo", piezo, 1'b0);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetStrikes", strikesLeft, 4'd0);
    rst = 1'b0;

    // Two keys held: key 7 (period 4) wins, then release.
    for (int i = 0; i < 20; i++) applyStimulus(8'h81, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    // Zero-strike trigger is ignored.
    applyStimulus(8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("zeroStrikeIdle", busy, 1'b0);

    // Three strikes with a key held and a second trigger mid-sequence.
    applyStimulus(8'h80, 1'b1, 4'd3, 1'b0, 1'b0);
    n = busy ? 1 : 0;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(8'h80, (i == 100), 4'd5, 1'b0, 1'b0);
      if (busy) n++;
    end
    checkOutput("busyLen3", n, 3 * SLEN);

    // Cancel during the low note of strike 2, key 0 held throughout.
    applyStimulus(8'h01, 1'b1, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < SLEN + TON + TGAP + 5; i++) applyStimulus(8'h01, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("cancelIdle", busy, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(8'h01, 1'b0, 4'd0, 1'b0, 1'b0);

    // Trigger and cancel together in IDLE: cancel wins.
    applyStimulus(8'h00, 1'b1, 4'd2, 1'b1, 1'b0);
    checkOutput("trigCancelIdle", busy, 1'b0);

    // Mute over strike 1 of a 2-strike chime; the sequence still ends on time.
    applyStimulus(8'h01, 1'b1, 4'd2, 1'b0, 1'b1);
    n = busy ? 1 : 0;
    for (int i = 0; i < SLEN; i++) begin
      applyStimulus(8'h01, 1'b0, 4'd0, 1'b0, 1'b1);
      if (busy) n++;
    end
    for (int i = 0; i < SLEN + 10; i++) begin
      applyStimulus(8'h01, 1'b0, 4'd0, 1'b0, 1'b0);
      if (busy) n++;
    end
    checkOutput("busyLen2Muted", n, 2 * SLEN);

    // Reset mid-sequence, then silence until a new trigger.
    applyStimulus(8'h00, 1'b1, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 45; i++) applyStimulus(8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    // Randomized traffic.
    rb = '0;
    rm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rb = NK'($urandom);
      if ($urandom_range(0, 99) == 0) rm = ~rm;
      if ($urandom_range(0, 999) == 0) doReset();
      applyStimulus(rb, ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 4)),
                    ($urandom_range(0, 199) == 0), rm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
